// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue sitting between instruction memory and the IF/ID register.
// Keeps one memory request in flight and buffers up to DEPTH {pc, inst} pairs for IF.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     out_valid,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_pc4,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    // state | meaning
    // IDLE  | no request outstanding; issue one next edge if there is room
    // REQ   | request outstanding on the correct path; ack pushes the word
    // DROP  | request outstanding on a flushed path; ack is swallowed
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push, pop;

    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!redirect && (count_q < CW'(DEPTH))) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                    if (!redirect) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else if (redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // A redirect always wins the fetch address; low bits are not addressable.
        if (redirect) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
        end
    end

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready && !redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            addr_q     <= 32'h0000_0000;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset: nothing reads it until count says it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            inst_mem[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_inst  = inst_mem[rd_ptr_q];
    assign out_pc4   = pc_mem[rd_ptr_q] + 32'd4;
    assign count     = count_q;

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Instruction prefetch buffer between the instruction memory and the IF/ID instruction register.
- Fetches sequential words from a variable-latency instruction memory ahead of the pipeline and holds up to DEPTH {pc, inst} pairs.
- Presents the head entry to IF with a valid/ready handshake. The ready input is driven by the hazard unit's PC/IR write enable.
- Flushes on branch/jump redirect, and discards any in-flight fetch made on the wrong path.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
redirect  in  1  flush queue and restart fetch (taken branch/jump from ID)
redirect_pc  in  32  new fetch address; bits [1:0] ignored, forced to 0
imem_req  out  1  fetch request, registered; held high until imem_ack
imem_addr  out  32  fetch address, registered; stable while imem_req=1
imem_ack  in  1  read data valid this cycle; only meaningful while imem_req=1
imem_rdata  in  32  instruction word
out_valid  out  1  head entry valid
out_inst  out  32  head instruction
out_pc  out  32  head instruction address
out_pc4  out  32  out_pc + 4
out_ready  in  1  consumer accepts head (wpcir)
count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async): state=IDLE, fetch_pc=RESET_PC, count=0, rd/wr pointers=0, imem_req=0, imem_addr=0, out_valid=0. Reset during an outstanding request abandons it; the memory must tolerate this.
- Storage: circular buffer with rd_ptr and wr_ptr of clog2(DEPTH) bits, wrapping modulo DEPTH. count is registered.
- out_valid = (count != 0). out_inst, out_pc and out_pc4 are driven combinationally from entry[rd_ptr]. They are don't-care when out_valid=0.
- At most one outstanding request. Only one request is ever in flight and requests start only when count < DEPTH, so a push can never overflow the queue.
- FSM:
  - IDLE: if no redirect and count < DEPTH, then next edge imem_req<=1, imem_addr<=fetch_pc, go REQ.
  - REQ: imem_req=1.
    - ack and no redirect: push {fetch_pc, imem_rdata}, fetch_pc+=4, imem_req<=0, go IDLE.
    - redirect and ack in the same cycle: data discarded, imem_req<=0, go IDLE.
    - redirect without ack: go DROP, with imem_req and imem_addr held.
  - DROP: imem_req stays 1 with the old address. On ack, discard data, imem_req<=0, go IDLE. A further redirect in DROP updates fetch_pc and stays in DROP.
- Redirect (any state):
  - Next edge: count<=0, rd_ptr<=wr_ptr<=0, fetch_pc<={redirect_pc[31:2],2'b00}.
  - Redirect has priority over pop and push in the same cycle.
  - out_valid is 0 in the cycle after a redirect.
- Pop occurs when out_valid & out_ready & !redirect: rd_ptr+=1, count-=1.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Latency:
  - A request is issued in the cycle after entering IDLE.
  - An acked word appears at out_valid in the cycle after the ack.
  - With imem_ack returned the same cycle as imem_req, the queue sustains one instruction per 2 cycles.
- fetch_pc arithmetic is 32-bit and wraps from 32'hFFFF_FFFC to 0 without error.
- Full queue: no request is issued. Fetching resumes in the cycle after count drops below DEPTH.

Test Plan:
1. Reset, memory acks on the 2nd request cycle with data = addr ^ 32'hA5A5_0000, out_ready=1.
   Required: out_pc sequence 0,4,8,C with matching out_inst; out_pc4 = out_pc+4.
2. out_ready=0, acks immediate.
   Required: count reaches 4, then imem_req stays 0 and out_pc holds 0. Raising out_ready drains 0,4,8,C in order and fetching resumes at 0x10.
3. Queue holds 2 entries, then redirect=1 with redirect_pc=32'h0000_0103 while no request is outstanding.
   Required: next cycle count=0 and out_valid=0; the next imem_addr is 32'h0000_0100.
4. Redirect to 0x200 while a request to 0x10 is pending, ack 3 cycles later with 32'hDEAD_BEEF.
   Required: DEAD_BEEF never appears on out_inst. The next request is to 0x200, and the first valid has out_pc=0x200.
5. Redirect and ack in the same cycle, and separately redirect and out_ready with count=1.
   Required: no push, no pop; count=0 next cycle.
6. Assert rst mid-request in REQ.
   Required: imem_req=0 and out_valid=0 immediately without a clock edge; after release, fetching restarts at RESET_PC.
